demux32_buf: RTL

//  1-to-8 routing buffer for 32-bit datapath values: the inverse of the 8:1 select mux.

---
 rtl/demux32_buf.sv | 101 ++++++++++
 1 files changed

// File: rtl/demux32_buf.sv
// demux32_buf: 1-to-8 routing buffer. Each input word is steered by `choose` into
// one of eight 1-entry channel buffers, each drained by its own valid/ready consumer.
module demux32_buf #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [SEL_W-1:0]                   choose,
    input  logic [WIDTH-1:0]                   in_data,
    output logic [(1<<SEL_W)-1:0]              out_valid,
    input  logic [(1<<SEL_W)-1:0]              out_ready,
    output logic [(1<<SEL_W)*WIDTH-1:0]        out_data,
    output logic [SEL_W:0]                     occupancy
);

    localparam int N = 1 << SEL_W;
    localparam logic [SEL_W:0] ONE = (SEL_W+1)'(1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Ready never depends on the matching valid; the producer holds data/choose while stalled.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    chan_state_e      state_q [N];
    chan_state_e      state_d [N];
    logic [WIDTH-1:0] data_q  [N];
    logic [WIDTH-1:0] data_d  [N];
    logic [SEL_W:0]   occ_q;
    logic [SEL_W:0]   occ_d;

    logic [N-1:0]     accept_vec;
    logic [N-1:0]     drain_vec;
    logic [SEL_W:0]   fill_cnt;
    logic [SEL_W:0]   drain_cnt;

    // A full channel can take a new word in the same cycle its consumer drains it.
    always_comb begin
        in_ready = reset & ((state_q[choose] == EMPTY) | out_ready[choose]);
    end

    always_comb begin
        accept_vec = '0;
        drain_vec  = '0;
        for (int k = 0; k < N; k++) begin
            accept_vec[k] = in_valid & in_ready & (choose == SEL_W'(k));
            drain_vec[k]  = (state_q[k] == FULL) & out_ready[k];
        end
    end

    always_comb begin
        fill_cnt  = '0;
        drain_cnt = '0;
        for (int k = 0; k < N; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (accept_vec[k]) begin
                state_d[k] = FULL;
                data_d[k]  = in_data;
                if (state_q[k] == EMPTY) begin
                    fill_cnt = fill_cnt + ONE;
                end
            end else if (drain_vec[k]) begin
                // Data is left in place after a drain; only the valid bit clears.
                state_d[k] = EMPTY;
                drain_cnt  = drain_cnt + ONE;
            end
        end
        occ_d = occ_q + fill_cnt - drain_cnt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            occ_q <= occ_d;
        end
    end

    // out_valid doubles as the observable per-channel FSM state (1 = FULL).
    always_comb begin
        for (int k = 0; k < N; k++) begin
            out_valid[k]                  = (state_q[k] == FULL);
            out_data[k*WIDTH +: WIDTH]    = data_q[k];
        end
        occupancy = occ_q;
    end

endmodule
